video_pattern_gen: RTL and testbench

//  Source end of the RGB888 + vsync/hsync/valid pixel stream consumed by the per-channel video processing

---
 rtl/vid_pattern_pkg.sv | 42 ++++
 rtl/vid_timing_counter.sv | 102 ++++++++++
 rtl/video_pattern_gen.sv | 141 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pattern_pkg.sv
// Shared encodings for the video test-pattern source: pattern modes, bar colours,
// raster sequencer states and the common counter width.
package vid_pattern_pkg;

    localparam int CNT_W = 12;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_GREY  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } vid_state_e;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_CYAN;
            3'd3:    col = COL_GREEN;
            3'd4:    col = COL_MAGENTA;
            3'd5:    col = COL_RED;
            3'd6:    col = COL_BLUE;
            default: col = COL_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/vid_timing_counter.sv
// Raster sequencer: run/stop FSM, horizontal and vertical position counters and
// the combinational active/sync decode of the current position.
module vid_timing_counter
    import vid_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             run_o,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    vid_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_end;
    logic             frame_end;

    assign h_end     = (h_q == H_LAST);
    assign frame_end = h_end && (v_q == V_LAST);

    // Next state and counter advance; a stop request only takes effect at the end of the frame.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_RUN;
                else      state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!en_i) state_d = frame_end ? ST_IDLE : ST_STOPPING;
                else       state_d = ST_RUN;
            end
            ST_STOPPING: begin
                if (en_i)           state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
                else                state_d = ST_STOPPING;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE) begin
            h_d = CNT_ZERO;
            v_d = CNT_ZERO;
        end else if (h_end) begin
            h_d = CNT_ZERO;
            v_d = (v_q == V_LAST) ? CNT_ZERO : (v_q + CNT_ONE);
        end else begin
            h_d = h_q + CNT_ONE;
        end
    end

    // State and position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_q     <= CNT_ZERO;
            v_q     <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign h_o      = h_q;
    assign v_o      = v_q;
    assign run_o    = (state_q != ST_IDLE);
    assign active_o = run_o && (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o  = run_o && (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync_o  = run_o && (v_q >= VS_BEG) && (v_q < VS_END);

endmodule

// File: rtl/video_pattern_gen.sv
// RGB888 test-pattern source: raster timing from vid_timing_counter, a per-frame
// latched pattern select, and one register stage aligning pixel, syncs and qualifiers.
module video_pattern_gen
    import vid_pattern_pkg::*;
#(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic SYNC_POL = 1'b1,
    parameter int   CHK_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [1:0]  i_mode,
    input  logic [23:0] i_solid_rgb,
    output logic [23:0] o_rgb888,
    output logic        o_vsync,
    output logic        o_hsync,
    output logic        o_vaild,
    output logic        o_frame_start
);

    localparam int               BAR_W    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] tc_h, tc_v;
    logic             tc_run, tc_active, tc_hsync, tc_vsync;
    logic             frame_first;

    logic [1:0]       mode_q, mode_d;
    logic [23:0]      solid_q, solid_d;
    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [23:0]      pix;

    logic [23:0]      rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             vaild_q, vaild_d;
    logic             fs_q, fs_d;

    vid_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .en_i     (i_en),
        .h_o      (tc_h),
        .v_o      (tc_v),
        .run_o    (tc_run),
        .active_o (tc_active),
        .hsync_o  (tc_hsync),
        .vsync_o  (tc_vsync)
    );

    assign frame_first = tc_run && (tc_h == CNT_ZERO) && (tc_v == CNT_ZERO);

    // Bar position tracks h through the active part of each line; the last bar absorbs any remainder.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (!tc_active) begin
            bar_cnt_d = CNT_ZERO;
            bar_idx_d = 3'd0;
        end else if (bar_idx_q == 3'd7) begin
            bar_cnt_d = bar_cnt_q;
            bar_idx_d = bar_idx_q;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = CNT_ZERO;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_cnt_d = bar_cnt_q + CNT_ONE;
        end
    end

    // Pattern select is taken live on the first pixel of a frame and frozen for the rest of it.
    always_comb begin
        mode_d  = frame_first ? i_mode      : mode_q;
        solid_d = frame_first ? i_solid_rgb : solid_q;
        case (mode_d)
            MODE_BARS:  pix = bar_colour(bar_idx_q);
            MODE_GREY:  pix = {tc_h[7:0], tc_h[7:0], tc_h[7:0]};
            MODE_CHECK: pix = (tc_h[CHK_LOG2] ^ tc_v[CHK_LOG2]) ? COL_WHITE : COL_BLACK;
            MODE_SOLID: pix = solid_d;
            default:    pix = COL_BLACK;
        endcase
        if (tc_active) rgb_d = pix;
        else           rgb_d = 24'h000000;
        vaild_d = tc_active;
        fs_d    = frame_first;
        hsync_d = tc_hsync ? SYNC_POL : ~SYNC_POL;
        vsync_d = tc_vsync ? SYNC_POL : ~SYNC_POL;
    end

    // Pattern state and the aligned output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_BARS;
            solid_q   <= 24'h000000;
            bar_cnt_q <= CNT_ZERO;
            bar_idx_q <= 3'd0;
            rgb_q     <= 24'h000000;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            vaild_q   <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            vaild_q   <= vaild_d;
            fs_q      <= fs_d;
        end
    end

    assign o_rgb888      = rgb_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_vaild       = vaild_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a small raster (24x7 clocks), with an
// active-high and an active-low sync instance driven from the same inputs.
module tb_video_pattern_gen;

    localparam int HA = 16, HFP = 2, HS = 2, HBP = 4, HT = 24;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1, VT = 7;
    localparam int FT = HT * VT;
    localparam int CHK = 1;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [1:0]  i_mode;
    logic [23:0] i_solid_rgb;
    logic [23:0] p_rgb, n_rgb;
    logic        p_vs, p_hs, p_valid, p_fs;
    logic        n_vs, n_hs, n_valid, n_fs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b1), .CHK_LOG2(CHK)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
        .o_rgb888(p_rgb), .o_vsync(p_vs), .o_hsync(p_hs), .o_vaild(p_valid),
        .o_frame_start(p_fs)
    );

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .CHK_LOG2(CHK)
    ) dut_n (
        .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
        .o_rgb888(n_rgb), .o_vsync(n_vs), .o_hsync(n_hs), .o_vaild(n_valid),
        .o_frame_start(n_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, hsync, vsync, fs, n_valid, n_fs, n_hsync, n_vsync} expected at frame position k
    function automatic logic [7:0] exp_ctrl(input int k, input bit run);
        int   h, v;
        logic va, hs, vs, fs;
        h  = k % HT;
        v  = k / HT;
        va = (h < HA) && (v < VA);
        hs = (h >= HA + HFP) && (h < HA + HFP + HS);
        vs = (v >= VA + VFP) && (v < VA + VFP + VS);
        fs = (k == 0);
        if (!run) return 8'b0000_0011;
        return {va, hs, vs, fs, va, fs, ~hs, ~vs};
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [1:0] m, input int k, input logic [23:0] s);
        int          h, v, idx;
        logic [31:0] hv;
        h  = k % HT;
        v  = k / HT;
        hv = h;
        if (h >= HA || v >= VA) return 24'h000000;
        case (m)
            2'd0: begin
                idx = h / (HA / 8);
                if (idx > 7) idx = 7;
                return bar_tab[idx];
            end
            2'd1:    return {hv[7:0], hv[7:0], hv[7:0]};
            2'd2:    return ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if ({p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs} !== 8'b0000_0011) begin
            n_fail++;
            $display("FAIL reset_ctrl actual=%b required=%b",
                     {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs}, 8'b0000_0011);
        end
        n_checks++;
        if ({p_rgb, n_rgb} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_rgb actual=%h/%h required=000000", p_rgb, n_rgb);
        end
        n_checks++;
        rst = 1'b0;
    endtask

    task automatic test_frame_timing();
        int vcnt, fcnt;
        logic [7:0] oc;
        vcnt = 0;
        fcnt = 0;
        i_en = 1'b1;
        @(negedge clk);
        oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
        if (oc !== 8'b0000_0011) begin
            n_fail++;
            $display("FAIL run_entry actual=%b required=%b", oc, 8'b0000_0011);
        end
        n_checks++;
        for (int k = 0; k < FT; k++) begin
            @(negedge clk);
            oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
            if (oc !== exp_ctrl(k, 1'b1)) begin
                n_fail++;
                $display("FAIL timing_ctrl k=%0d actual=%b required=%b", k, oc, exp_ctrl(k, 1'b1));
            end
            n_checks++;
            if ({p_rgb, n_rgb} !== {2{exp_rgb(2'd0, k, 24'h0)}}) begin
                n_fail++;
                $display("FAIL bars_rgb k=%0d actual=%h required=%h", k, p_rgb, exp_rgb(2'd0, k, 24'h0));
            end
            n_checks++;
            if (p_valid === 1'b1) vcnt++;
            if (p_fs === 1'b1) fcnt++;
        end
        if (vcnt != 64 || fcnt != 1) begin
            n_fail++;
            $display("FAIL frame_counts actual=%0d valid/%0d fs required=64/1", vcnt, fcnt);
        end
        n_checks++;
    endtask

    task automatic test_mode_switch();
        logic [1:0]  m;
        logic [23:0] e;
        i_mode = 2'd2;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FT; k++) begin
                @(negedge clk);
                m = (f == 0) ? 2'd2 : 2'd3;
                e = exp_rgb(m, k, 24'h123456);
                if (p_rgb !== e || p_valid !== exp_ctrl(k, 1'b1)[7]) begin
                    n_fail++;
                    $display("FAIL mode_switch f=%0d k=%0d actual=%h/%b required=%h/%b",
                             f, k, p_rgb, p_valid, e, exp_ctrl(k, 1'b1)[7]);
                end
                n_checks++;
                if (f == 0 && k == 50) begin
                    i_mode      = 2'd3;
                    i_solid_rgb = 24'h123456;
                end
                if (f == 1 && k == 30) i_solid_rgb = 24'hABCDEF;
                if (f == 1 && k == 60) i_mode = 2'd0;
            end
        end
    endtask

    task automatic test_back_to_back();
        i_mode = 2'd1;
        for (int k = 0; k < FT; k++) begin
            @(negedge clk);
            if (p_fs !== (k == 0) || p_rgb !== exp_rgb(2'd1, k, 24'h0)) begin
                n_fail++;
                $display("FAIL grey_b2b k=%0d actual=%h/%b required=%h/%b",
                         k, p_rgb, p_fs, exp_rgb(2'd1, k, 24'h0), (k == 0));
            end
            n_checks++;
        end
    endtask

    task automatic test_stop();
        int vcnt, fcnt;
        logic [7:0] oc;
        vcnt = 0;
        fcnt = 0;
        for (int k = 0; k < 2 * FT; k++) begin
            @(negedge clk);
            oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
            if (oc !== exp_ctrl(k % FT, k < FT) || p_rgb !== ((k < FT) ? exp_rgb(2'd1, k, 24'h0) : 24'h0)) begin
                n_fail++;
                $display("FAIL stop k=%0d actual=%b/%h required=%b/%h", k, oc, p_rgb,
                         exp_ctrl(k % FT, k < FT), (k < FT) ? exp_rgb(2'd1, k, 24'h0) : 24'h0);
            end
            n_checks++;
            if (p_valid === 1'b1) vcnt++;
            if (p_fs === 1'b1) fcnt++;
            if (k == 40) i_en = 1'b0;
        end
        if (vcnt != 64 || fcnt != 1) begin
            n_fail++;
            $display("FAIL stop_counts actual=%0d valid/%0d fs required=64/1", vcnt, fcnt);
        end
        n_checks++;
    endtask

    task automatic test_restart_in_stop();
        logic [7:0] oc;
        i_en = 1'b1;
        @(negedge clk);
        if (p_fs !== 1'b0 || p_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_entry actual=%b%b required=00", p_fs, p_valid);
        end
        n_checks++;
        for (int k = 0; k < 2 * FT; k++) begin
            @(negedge clk);
            oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
            if (oc !== exp_ctrl(k % FT, 1'b1) || p_rgb !== exp_rgb(2'd1, k % FT, 24'h0)) begin
                n_fail++;
                $display("FAIL restart k=%0d actual=%b/%h required=%b/%h", k, oc, p_rgb,
                         exp_ctrl(k % FT, 1'b1), exp_rgb(2'd1, k % FT, 24'h0));
            end
            n_checks++;
            if (k == 100) i_en = 1'b0;
            if (k == 150) i_en = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] oc;
        for (int k = 0; k <= 30; k++) @(negedge clk);
        oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
        if (oc !== exp_ctrl(30, 1'b1)) begin
            n_fail++;
            $display("FAIL pre_reset actual=%b required=%b", oc, exp_ctrl(30, 1'b1));
        end
        n_checks++;
        rst = 1'b1;
        #1;
        oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
        if (oc !== 8'b0000_0011 || {p_rgb, n_rgb} !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset actual=%b/%h required=%b/000000", oc, p_rgb, 8'b0000_0011);
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
        if (oc !== 8'b0000_0011) begin
            n_fail++;
            $display("FAIL reset_reentry actual=%b required=%b", oc, 8'b0000_0011);
        end
        n_checks++;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            oc = {p_valid, p_hs, p_vs, p_fs, n_valid, n_fs, n_hs, n_vs};
            if (oc !== exp_ctrl(k, 1'b1) || p_rgb !== exp_rgb(2'd1, k, 24'h0)) begin
                n_fail++;
                $display("FAIL after_reset k=%0d actual=%b/%h required=%b/%h", k, oc, p_rgb,
                         exp_ctrl(k, 1'b1), exp_rgb(2'd1, k, 24'h0));
            end
            n_checks++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_en        = 1'b0;
        i_mode      = 2'd0;
        i_solid_rgb = 24'h000000;
        test_reset();
        test_frame_timing();
        test_mode_switch();
        test_back_to_back();
        test_stop();
        test_restart_in_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
